pc_fetch: RTL and testbench
===========================

# pc_fetch

Fetch-stage controller for the MIPS single-cycle core. It owns the program counter, drives `read_addr` of `instruction_mem`, and registers the returned `instruction` into a fetch output register for the decode/control stage. It also applies branch, jump, stall and halt requests from downstream.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset; must be word-aligned.

Ports (clock and reset first):
- `clk`  in  1: single clock; all state updates on the rising edge.
- `reset`  in  1: asynchronous, active-high reset.
- `stall`  in  1: freezes all fetch state.
- `branch_taken`  in  1: redirect to the branch target.
- `branch_offset`  in  32: sign-extended word offset.
- `jump`  in  1: redirect to the jump target.
- `jump_index`  in  26: jump word index.
- `halt`  in  1: stop fetching.
- `instruction`  in  32: combinational read data from `instruction_mem`.
- `read_addr`  out  32: equals internal `pc`; goes to `instruction_mem`.
- `instr_out`  out  32: registered fetched instruction.
- `pc_out`  out  32: address of `instr_out`.
- `pc_plus4`  out  32: combinational, `pc_out + 4`.
- `instr_valid`  out  1: `instr_out` holds a valid instruction.
- `halted`  out  1: HALT state.
- `misalign`  out  1: TRAP state; present only with `FETCH_ALIGN_TRAP_EN`.

## Operation
- State machine:
  - BOOT: entered on reset.
  - RUN.
  - HALT: terminal until reset.
  - TRAP: macro build only; terminal until reset.
- **BOOT -> RUN** on the first edge after reset release, unless `stall` is high:
  - `instr_out <= instruction`, `pc_out <= pc`, `pc <= pc + 4`, `instr_valid <= 1`.
- **RUN**, edge with `stall` = 0. Redirect requests are qualified by `instr_valid` = 1 and refer to the instruction in `instr_out`. Priority is `halt` > `jump` > `branch_taken` > sequential:
  - Sequential: same update as BOOT -> RUN.
  - `jump`: `pc <= {pc_plus4[31:28], jump_index, 2'b00}`, `instr_valid <= 0`.
  - `branch_taken`: `pc <= pc_plus4 + (branch_offset << 2)`, `instr_valid <= 0`.
  - Redirect cost: one bubble. `instr_out` and `pc_out` hold their old values while invalid.
  - `halt`: go to HALT, `instr_valid <= 0`, `pc` holds, `halted <= 1`.
- **Any state, `stall` = 1:**
  - Every register holds.
  - Redirect and halt requests are ignored. The consumer keeps them asserted until `stall` drops.
- **Redirect and halt with `instr_valid` = 0:** ignored.
- **HALT:** `read_addr` holds, `instr_valid` = 0. Only `reset` leaves it.
- **Arithmetic:** all 32-bit modulo 2^32. PC 32'hFFFF_FFFC + 4 wraps to 0 with no flag. Branch target overflow wraps silently.

## Timing
- Reset values:
  - `pc` / `read_addr` = `RESET_PC`.
  - `instr_out` = 0, `pc_out` = 0, `instr_valid` = 0, `halted` = 0, `misalign` = 0.
  - `pc_plus4` = 4, since it is derived from `pc_out`.
- Reset asserted mid-operation clears all state immediately, with no wait for a clock edge.
- `read_addr` changes only after a rising edge or reset. `instruction` must settle within the same cycle, since the memory read is combinational.
- Latency from `read_addr` to `instr_out`: 1 edge.
- Redirect to first valid target instruction: 2 edges. Edge 1 loads `pc`; edge 2 registers the target instruction.
- Stall release: fetch resumes on the first edge with `stall` = 0.
- Simultaneous `halt` and `jump` with `instr_valid` = 1: HALT wins, and `pc` does not take the jump target.

## Configuration
- Macro `FETCH_ALIGN_TRAP_EN`.
- **Defined:**
  - A qualified jump or branch whose target has bits [1:0] != 0 enters TRAP.
  - In TRAP: `misalign` = 1, `instr_valid` = 0, and `pc` holds its pre-redirect value.
  - Only `reset` exits TRAP.
  - A jump target is always aligned by construction, so in practice only a branch can trap.
- **Undefined:**
  - No `misalign` port and no TRAP state.
  - Target bits [1:0] are forced to 0 before loading `pc`.

## Test plan
- **Reset and boot:** `RESET_PC` = 0, hold `reset` 2 cycles, release; memory holds word 0 = 32'h2008_0005 and word 1 = 32'h2009_0003.
  - Before the first edge: `read_addr` = 0, `instr_valid` = 0.
  - After edge 1: `instr_out` = 32'h2008_0005, `pc_out` = 0, `read_addr` = 4.
- **Sequential run:** 4 edges without stall.
  - `pc_out` steps 0, 4, 8, 12.
  - `instr_valid` stays 1.
  - `pc_plus4` always equals `pc_out` + 4.
- **Branch:** at `pc_out` = 8, pulse `branch_taken` with `branch_offset` = 32'hFFFF_FFFE.
  - Next edge: `read_addr` = 4, `instr_valid` = 0.
  - Following edge: `pc_out` = 4, `instr_valid` = 1.
- **Jump:** at `pc_out` = 12, assert `jump` and `branch_taken` together with `jump_index` = 26'h10.
  - The jump wins: `read_addr` = 32'h40.
  - Then `pc_out` = 32'h40.
- **Stall plus halt:** raise `stall` for 3 edges with `halt` high.
  - All outputs are frozen.
  - `stall` drops: the next edge gives `halted` = 1, `instr_valid` = 0.
  - A further 5 edges leave `read_addr` unchanged.
  - `reset` returns `read_addr` to `RESET_PC` asynchronously.
- **Wrap and alignment:** `RESET_PC` = 32'hFFFF_FFFC.
  - After 2 edges, `read_addr` = 4.
  - With `FETCH_ALIGN_TRAP_EN`: `branch_offset` = 0 from a modified target path is aligned. Force misalignment by configuring `RESET_PC` = 32'h0000_0002; the first redirect sets `misalign` = 1.
  - Without the macro: the same stimulus gives `read_addr[1:0]` = 0.

Source files
------------

// File: rtl/pc_fetch.sv
// Fetch-stage controller: owns the PC, registers fetched instructions and applies
// stall/halt/jump/branch requests. Optional macro FETCH_ALIGN_TRAP_EN adds the TRAP state.
module pc_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_offset,
    input  logic        jump,
    input  logic [25:0] jump_index,
    input  logic        halt,
    input  logic [31:0] instruction,
    output logic [31:0] read_addr,
    output logic [31:0] instr_out,
    output logic [31:0] pc_out,
    output logic [31:0] pc_plus4,
    output logic        instr_valid,
`ifdef FETCH_ALIGN_TRAP_EN
    output logic        misalign,
`endif
    output logic        halted
);

    localparam logic [1:0] ST_BOOT = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_HALT = 2'd2;
    localparam logic [1:0] ST_TRAP = 2'd3;

    logic [1:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_out_q, pc_out_d;
    logic        valid_q, valid_d;
    logic        halted_q, halted_d;
    logic        misalign_q, misalign_d;

    logic [31:0] pc_plus4_s;
    logic [31:0] jump_tgt_s;
    logic [31:0] branch_tgt_s;
    logic [31:0] redir_tgt_s;
    logic        redir_s;

    assign pc_plus4_s   = pc_out_q + 32'd4;
    assign jump_tgt_s   = {pc_plus4_s[31:28], jump_index, 2'b00};
    assign branch_tgt_s = pc_plus4_s + (branch_offset << 2);
    assign redir_tgt_s  = jump ? jump_tgt_s : branch_tgt_s;
    assign redir_s      = jump | branch_taken;

    // Next-state logic; redirects and halt only count when instr_out is valid.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        pc_out_d   = pc_out_q;
        valid_d    = valid_q;
        halted_d   = halted_q;
        misalign_d = misalign_q;
        case (state_q)
            ST_BOOT, ST_RUN: begin
                if (stall) begin
                    state_d = state_q;
                end else if ((state_q == ST_RUN) && valid_q && halt) begin
                    state_d  = ST_HALT;
                    valid_d  = 1'b0;
                    halted_d = 1'b1;
                end else if ((state_q == ST_RUN) && valid_q && redir_s) begin
                    valid_d = 1'b0;
`ifdef FETCH_ALIGN_TRAP_EN
                    if (redir_tgt_s[1:0] != 2'b00) begin
                        state_d    = ST_TRAP;
                        misalign_d = 1'b1;
                    end else begin
                        pc_d = redir_tgt_s;
                    end
`else
                    pc_d = redir_tgt_s & 32'hFFFF_FFFC;
`endif
                end else begin
                    state_d  = ST_RUN;
                    instr_d  = instruction;
                    pc_out_d = pc_q;
                    pc_d     = pc_q + 32'd4;
                    valid_d  = 1'b1;
                end
            end
            ST_HALT: valid_d = 1'b0;
            ST_TRAP: valid_d = 1'b0;
            default: state_d = ST_BOOT;
        endcase
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_BOOT;
            pc_q       <= RESET_PC;
            instr_q    <= 32'd0;
            pc_out_q   <= 32'd0;
            valid_q    <= 1'b0;
            halted_q   <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            pc_out_q   <= pc_out_d;
            valid_q    <= valid_d;
            halted_q   <= halted_d;
            misalign_q <= misalign_d;
        end
    end

    assign read_addr   = pc_q;
    assign instr_out   = instr_q;
    assign pc_out      = pc_out_q;
    assign pc_plus4    = pc_plus4_s;
    assign instr_valid = valid_q;
    assign halted      = halted_q;
`ifdef FETCH_ALIGN_TRAP_EN
    assign misalign    = misalign_q;
`else
    logic unused_s;
    assign unused_s = misalign_q;
`endif

endmodule

// File: tb/tb_pc_fetch.sv
// Directed bench for pc_fetch: boot, sequential fetch, branch, jump, stall/halt,
// async reset, PC wrap and target alignment (three instances with different RESET_PC).
module tb_pc_fetch;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_offset;
    logic        jump;
    logic [25:0] jump_index;
    logic        halt;

    logic [31:0] ra1, io1, po1, pp1, ra2, io2, po2, pp2, ra3, io3, po3, pp3;
    logic        iv1, h1, iv2, h2, iv3, h3;
`ifdef FETCH_ALIGN_TRAP_EN
    logic        mis1, mis2, mis3;
`endif

    int errors = 0;
    int checks = 0;

    function automatic logic [31:0] imem(input logic [31:0] a);
        case (a)
            32'h0000_0000: imem = 32'h2008_0005;
            32'h0000_0004: imem = 32'h2009_0003;
            default:       imem = {16'hC0DE, a[15:0]};
        endcase
    endfunction

    pc_fetch #(.RESET_PC(32'h0000_0000)) u_dut (
        .clk(clk), .reset(reset), .stall(stall), .branch_taken(branch_taken),
        .branch_offset(branch_offset), .jump(jump), .jump_index(jump_index), .halt(halt),
        .instruction(imem(ra1)), .read_addr(ra1), .instr_out(io1), .pc_out(po1),
        .pc_plus4(pp1), .instr_valid(iv1),
`ifdef FETCH_ALIGN_TRAP_EN
        .misalign(mis1),
`endif
        .halted(h1)
    );

    pc_fetch #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
        .clk(clk), .reset(reset), .stall(stall), .branch_taken(branch_taken),
        .branch_offset(branch_offset), .jump(jump), .jump_index(jump_index), .halt(halt),
        .instruction(imem(ra2)), .read_addr(ra2), .instr_out(io2), .pc_out(po2),
        .pc_plus4(pp2), .instr_valid(iv2),
`ifdef FETCH_ALIGN_TRAP_EN
        .misalign(mis2),
`endif
        .halted(h2)
    );

    pc_fetch #(.RESET_PC(32'h0000_0002)) u_odd (
        .clk(clk), .reset(reset), .stall(stall), .branch_taken(branch_taken),
        .branch_offset(branch_offset), .jump(jump), .jump_index(jump_index), .halt(halt),
        .instruction(imem(ra3)), .read_addr(ra3), .instr_out(io3), .pc_out(po3),
        .pc_plus4(pp3), .instr_valid(iv3),
`ifdef FETCH_ALIGN_TRAP_EN
        .misalign(mis3),
`endif
        .halted(h3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        if (obs !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_offset = 32'd0;
        jump = 1'b0; jump_index = 26'd0; halt = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        check_eq("rst_read_addr", ra1, 32'h0000_0000);
        check_eq("rst_valid", {31'd0, iv1}, 32'd0);
        check_eq("rst_instr_out", io1, 32'd0);
        check_eq("rst_pc_out", po1, 32'd0);
        check_eq("rst_pc_plus4", pp1, 32'd4);
        check_eq("rst_halted", {31'd0, h1}, 32'd0);
        check_eq("rst_wrap_addr", ra2, 32'hFFFF_FFFC);

        tick(); // edge 1
        check_eq("e1_instr_out", io1, 32'h2008_0005);
        check_eq("e1_pc_out", po1, 32'd0);
        check_eq("e1_read_addr", ra1, 32'd4);
        check_eq("e1_valid", {31'd0, iv1}, 32'd1);
        check_eq("e1_wrap_pc_out", po2, 32'hFFFF_FFFC);
        check_eq("e1_wrap_plus4", pp2, 32'd0);
        check_eq("e1_wrap_addr", ra2, 32'd0);

        tick(); // edge 2
        check_eq("e2_pc_out", po1, 32'd4);
        check_eq("e2_instr_out", io1, 32'h2009_0003);
        check_eq("e2_pc_plus4", pp1, 32'd8);
        check_eq("e2_wrap_addr", ra2, 32'd4);

        tick(); // edge 3
        check_eq("e3_pc_out", po1, 32'd8);
        check_eq("e3_pc_plus4", pp1, 32'd12);
        branch_taken = 1'b1; branch_offset = 32'hFFFF_FFFE;

        tick(); // edge 4: branch redirect
        check_eq("br_read_addr", ra1, 32'd4);
        check_eq("br_valid", {31'd0, iv1}, 32'd0);
        check_eq("br_pc_out_hold", po1, 32'd8);
`ifdef FETCH_ALIGN_TRAP_EN
        check_eq("odd_misalign", {31'd0, mis3}, 32'd1);
        check_eq("odd_pc_hold", ra3, 32'd14);
        check_eq("main_no_trap", {31'd0, mis1}, 32'd0);
`else
        check_eq("odd_aligned_addr", ra3, 32'd4);
`endif
        branch_taken = 1'b0; branch_offset = 32'd0;

        tick(); // edge 5: branch target fetched
        check_eq("bt_pc_out", po1, 32'd4);
        check_eq("bt_valid", {31'd0, iv1}, 32'd1);
        check_eq("bt_instr", io1, 32'h2009_0003);
        check_eq("bt_read_addr", ra1, 32'd8);

        tick();
        tick(); // edge 7
        check_eq("e7_pc_out", po1, 32'd12);
        jump = 1'b1; branch_taken = 1'b1; branch_offset = 32'h0000_0010; jump_index = 26'h10;

        tick(); // edge 8: jump beats branch
        check_eq("jmp_read_addr", ra1, 32'h0000_0040);
        check_eq("jmp_valid", {31'd0, iv1}, 32'd0);
        branch_taken = 1'b0; branch_offset = 32'd0;

        tick(); // edge 9: jump held while invalid must be ignored
        check_eq("jt_pc_out", po1, 32'h0000_0040);
        check_eq("jt_read_addr", ra1, 32'h0000_0044);
        check_eq("jt_valid", {31'd0, iv1}, 32'd1);
        check_eq("jt_instr", io1, 32'hC0DE_0040);
        jump = 1'b0; jump_index = 26'd0;

        stall = 1'b1; halt = 1'b1;
        repeat (3) tick();
        check_eq("st_read_addr", ra1, 32'h0000_0044);
        check_eq("st_pc_out", po1, 32'h0000_0040);
        check_eq("st_valid", {31'd0, iv1}, 32'd1);
        check_eq("st_halted", {31'd0, h1}, 32'd0);
        check_eq("st_instr", io1, 32'hC0DE_0040);

        stall = 1'b0;
        tick();
        check_eq("ht_halted", {31'd0, h1}, 32'd1);
        check_eq("ht_valid", {31'd0, iv1}, 32'd0);
        check_eq("ht_read_addr", ra1, 32'h0000_0044);
        halt = 1'b0;
        repeat (5) tick();
        check_eq("ht_hold_addr", ra1, 32'h0000_0044);
        check_eq("ht_hold_halted", {31'd0, h1}, 32'd1);
        check_eq("ht_hold_valid", {31'd0, iv1}, 32'd0);

        #3 reset = 1'b1;
        #1;
        check_eq("ar_read_addr", ra1, 32'h0000_0000);
        check_eq("ar_halted", {31'd0, h1}, 32'd0);
        check_eq("ar_pc_out", po1, 32'd0);
        check_eq("ar_pc_plus4", pp1, 32'd4);
        reset = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
